// File: rtl/div17.sv
// div17: multi-cycle signed divider, 17-bit 2's complement sample / 8-bit Q1.7 coefficient -> 17-bit quotient.
// Build macro ROUND_EN: round half away from zero; default truncates toward zero.
module div17 #(
  parameter int DW = 17,
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_17bit,
  input  logic [TW-1:0] in_8bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out,
  output logic          ovf,
  output logic          dz
);
  localparam int NW = DW + TW - 1;
  localparam int CW = $clog2(NW);
  localparam logic [DW-1:0] POS_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] a_q, a_d;
  logic [TW-1:0] b_q, b_d;
  logic [TW-1:0] absb_q, absb_d;
  logic          sign_q, sign_d;
  logic          aneg_q, aneg_d;
  logic          zero_q, zero_d;
  logic [NW-1:0] num_q, num_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [TW-1:0] rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] out_q, out_d;
  logic          ovf_q, ovf_d;
  logic          dz_q, dz_d;
  logic          out_valid_q, out_valid_d;

  logic [DW-1:0] abs_a_s;
  logic [TW-1:0] abs_b_s;
  logic [TW:0]   rem_sh_s;
  logic          rem_ge_s;
  logic [NW:0]   qm_s;
  logic          pos_sat_s;
  logic          neg_sat_s;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

  // Operand magnitudes, one restoring step, and the (optionally rounded) quotient magnitude
  always_comb begin
    abs_a_s  = a_q[DW-1] ? (~a_q + {{(DW-1){1'b0}}, 1'b1}) : a_q;
    abs_b_s  = b_q[TW-1] ? (~b_q + {{(TW-1){1'b0}}, 1'b1}) : b_q;
    rem_sh_s = {rem_q, num_q[NW-1]};
    rem_ge_s = (rem_sh_s >= {1'b0, absb_q});
`ifdef ROUND_EN
    qm_s = ({rem_q, 1'b0} >= {1'b0, absb_q}) ? ({1'b0, quo_q} + {{NW{1'b0}}, 1'b1})
                                             : {1'b0, quo_q};
`else
    qm_s = {1'b0, quo_q};
`endif
    // Negative results may reach exactly 2^(DW-1); positive ones stop one short
    pos_sat_s = |qm_s[NW:DW-1];
    neg_sat_s = (|qm_s[NW:DW]) | (qm_s[DW-1] & (|qm_s[DW-2:0]));
  end

  // Next-state and datapath updates for the sequencer
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    absb_d      = absb_q;
    sign_d      = sign_q;
    aneg_d      = aneg_q;
    zero_d      = zero_q;
    num_d       = num_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    ovf_d       = ovf_q;
    dz_d        = dz_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_17bit;
          b_d     = in_8bit;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        sign_d  = a_q[DW-1] ^ b_q[TW-1];
        aneg_d  = a_q[DW-1];
        zero_d  = (b_q == {TW{1'b0}});
        absb_d  = abs_b_s;
        num_d   = {abs_a_s, {(TW-1){1'b0}}};
        quo_d   = {NW{1'b0}};
        rem_d   = {TW{1'b0}};
        cnt_d   = CW'(NW - 1);
        state_d = DIV;
      end
      DIV: begin
        rem_d = rem_ge_s ? TW'(rem_sh_s - {1'b0, absb_q}) : TW'(rem_sh_s);
        quo_d = {quo_q[NW-2:0], rem_ge_s};
        num_d = {num_q[NW-2:0], 1'b0};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        dz_d        = zero_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (zero_q) begin
          out_d = aneg_q ? NEG_MIN : POS_MAX;
          ovf_d = 1'b0;
        end else if (!sign_q && pos_sat_s) begin
          out_d = POS_MAX;
          ovf_d = 1'b1;
        end else if (sign_q && neg_sat_s) begin
          out_d = NEG_MIN;
          ovf_d = 1'b1;
        end else begin
          // Negating a zero magnitude yields +0, so no negative zero escapes
          out_d = sign_q ? (~qm_s[DW-1:0] + {{(DW-1){1'b0}}, 1'b1}) : qm_s[DW-1:0];
          ovf_d = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= {DW{1'b0}};
      b_q         <= {TW{1'b0}};
      absb_q      <= {TW{1'b0}};
      sign_q      <= 1'b0;
      aneg_q      <= 1'b0;
      zero_q      <= 1'b0;
      num_q       <= {NW{1'b0}};
      quo_q       <= {NW{1'b0}};
      rem_q       <= {TW{1'b0}};
      cnt_q       <= {CW{1'b0}};
      out_q       <= {DW{1'b0}};
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      absb_q      <= absb_d;
      sign_q      <= sign_d;
      aneg_q      <= aneg_d;
      zero_q      <= zero_d;
      num_q       <= num_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      ovf_q       <= ovf_d;
      dz_q        <= dz_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule
